// File: rtl/muldiv_seq.sv
// muldiv_seq: sequencer between the main control FSM and an external
// multiply/divide unit. It latches an operation, enables the selected unit,
// waits (with a bounded timeout) for its completion strobe and commits the
// result to the architectural HI/LO registers.
//
// Ports:
//   clk, reset                  rising-edge clock, asynchronous active-low reset
//   op_start, op_sel            request (sampled only in IDLE); 0 = MULT, 1 = DIV
//   op_a, op_b                  operands, latched on accept
//   mult_ctrl, div_ctrl         unit enables, high through LAUNCH and WAIT
//   unit_a, unit_b              latched operands, stable while busy
//   unit_done, unit_hi, unit_lo unit completion strobe and results
//   hi, lo                      architectural HI/LO registers
//   busy, done                  not-IDLE indicator, one-cycle completion pulse
//   div_zero, timeout           sticky status flags, cleared on the next accept
//   dbg_state                   current FSM state encoding
//
// Handshake: op_start is a level request that is taken on a rising edge only
// while the block is IDLE; there is no back-pressure and nothing is queued, so
// a request raised while busy is simply dropped. unit_done is a one-cycle
// strobe that counts only in WAIT, with unit_hi/unit_lo valid in that cycle.
module muldiv_seq #(
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_start,
  input  logic        op_sel,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        mult_ctrl,
  output logic        div_ctrl,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  input  logic        unit_done,
  input  logic [31:0] unit_hi,
  input  logic [31:0] unit_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        timeout,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DZERO   = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  localparam logic [5:0] LAST = 6'(TIMEOUT - 1);

  state_t      state;
  state_t      next_state;
  logic        sel_q;
  logic [5:0]  cnt;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        accept;
  logic        is_dz;
  logic        unit_active;

  assign accept      = (state == S_IDLE) && op_start;
  assign is_dz       = op_sel && (op_b == 32'd0);
  assign unit_active = (state == S_LAUNCH) || (state == S_WAIT);

  // Enables and status are decoded straight from the state register so that
  // an asynchronous reset drops them in the same cycle.
  assign mult_ctrl = unit_active && !sel_q;
  assign div_ctrl  = unit_active && sel_q;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_CAPTURE) || (state == S_DZERO) || (state == S_FAULT);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (op_start) next_state = is_dz ? S_DZERO : S_LAUNCH;
      S_LAUNCH:  next_state = S_WAIT;
      // unit_done is checked first so a completion on the last allowed cycle
      // still counts as a success.
      S_WAIT: begin
        if (unit_done)        next_state = S_CAPTURE;
        else if (cnt == LAST) next_state = S_FAULT;
      end
      S_CAPTURE: next_state = S_IDLE;
      S_DZERO:   next_state = S_IDLE;
      S_FAULT:   next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q    <= 1'b0;
      unit_a   <= 32'd0;
      unit_b   <= 32'd0;
      cnt      <= 6'd0;
      res_hi   <= 32'd0;
      res_lo   <= 32'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      div_zero <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (accept) begin
        unit_a   <= op_a;
        unit_b   <= op_b;
        sel_q    <= op_sel;
        // Flags are cleared by a new accept; a divide-by-zero is flagged at
        // once so the flag is already visible alongside its done pulse.
        div_zero <= is_dz;
        timeout  <= 1'b0;
      end
      if (state == S_LAUNCH) cnt <= 6'd0;
      if (state == S_WAIT) begin
        if (unit_done) begin
          // Unit results are only guaranteed alongside the strobe, so they
          // are held here for the CAPTURE write.
          res_hi <= unit_hi;
          res_lo <= unit_lo;
        end else if (cnt == LAST) begin
          timeout <= 1'b1;
        end else begin
          cnt <= cnt + 6'd1;
        end
      end
      if (state == S_CAPTURE) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, default 40, the maximum WAIT cycles allowed before declaring a unit fault.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 op_start  in  1  request from the main control FSM; sampled only in IDLE.
REQ-006 op_sel  in  1  0 = MULT, 1 = DIV.
REQ-007 op_a  in  32  dividend / multiplicand.
REQ-008 op_b  in  32  divisor / multiplier.
REQ-009 mult_ctrl  out  1  enable to the multiplier, held high for the whole operation.
REQ-010 div_ctrl  out  1  enable to the divider, held high for the whole operation.
REQ-011 unit_a, unit_b  out  32 each  latched operands, stable while busy.
REQ-012 unit_done  in  1  completion strobe from the selected unit.
REQ-013 unit_hi, unit_lo  in  32 each  unit results, valid with unit_done.
REQ-014 hi, lo  out  32 each  architectural HI/LO registers.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 div_zero  out  1  sticky divide-by-zero flag.
REQ-018 timeout  out  1  sticky unit-fault flag.

Function
REQ-019 The state machine SHALL have the states IDLE, LAUNCH, WAIT, CAPTURE, DZERO and FAULT.
REQ-020 In IDLE with op_start=1, the block SHALL latch op_a, op_b and op_sel into unit_a, unit_b and a select register, and clear div_zero and timeout.
- Next state: DZERO if op_sel=1 and op_b==0, otherwise LAUNCH.
REQ-021 op_start SHALL be ignored in every state other than IDLE; a request is never queued.
REQ-022 In LAUNCH and WAIT, exactly one of mult_ctrl/div_ctrl SHALL be high, selected by the latched op_sel; both SHALL be low in all other states.
REQ-023 LAUNCH SHALL last exactly one cycle, clear the 6-bit wait counter, and ignore unit_done.
REQ-024 WAIT behaviour per cycle:
- unit_done=1: go to CAPTURE.
- unit_done=0 and counter==TIMEOUT-1: go to FAULT.
- otherwise: increment the counter.
- unit_done SHALL win over the timeout when both occur in the same cycle.
REQ-025 CAPTURE SHALL write hi<=unit_hi and lo<=unit_lo, assert done for one cycle, then return to IDLE.
REQ-026 DZERO SHALL set div_zero, assert done, leave hi/lo unchanged, never raise either ctrl, then return to IDLE.
REQ-027 FAULT SHALL set timeout, assert done, leave hi/lo unchanged, then return to IDLE.
REQ-028 unit_done SHALL be ignored in IDLE, LAUNCH, CAPTURE, DZERO and FAULT.
REQ-029 Latency: a request accepted at edge N with unit_done high in the k-th WAIT cycle (k ≥ 1) SHALL produce done during cycle N+2+k, with hi/lo updated at its end; a DIV-by-zero request SHALL produce done during cycle N+1.
REQ-030 Back-to-back operation: a new op_start is accepted in the first IDLE cycle after done, giving a minimum spacing of one idle cycle between done pulses.
REQ-031 div_zero and timeout SHALL hold their value until the next accepted op_start or reset.
REQ-032 Operand signedness is the unit's concern; this block SHALL pass all 32 bits unmodified.

Reset
REQ-033 On reset low (asynchronous), the block SHALL go to IDLE and clear hi, lo, unit_a, unit_b, the counter, busy, done, div_zero, timeout, mult_ctrl and div_ctrl to 0.
REQ-034 Reset during LAUNCH or WAIT SHALL drop the active ctrl in the same cycle, and no capture SHALL occur afterwards.
REQ-035 The first op_start accepted SHALL be on the first rising edge after reset deasserts.

Verification
REQ-036 MULT, op_a=7, op_b=6; unit_done with hi=0, lo=42 in the 3rd WAIT cycle -> mult_ctrl high for 4 cycles, done 5 cycles after accept, hi=0, lo=42, div_ctrl never high.
REQ-037 DIV, op_a=100, op_b=0 -> div_zero=1 and done one cycle after accept, div_ctrl never high, hi/lo keep their previous values.
REQ-038 DIV, op_a=100, op_b=7; unit never strobes done -> div_ctrl high for 41 cycles, then timeout=1, done pulse, hi/lo unchanged.
REQ-039 unit_done and counter==TIMEOUT-1 in the same cycle -> CAPTURE taken, timeout stays 0, hi/lo updated.
REQ-040 op_start pulsed while busy, then a second op_start the cycle after done -> the first extra request is dropped and the second is accepted, with operands latched from that cycle.
REQ-041 reset asserted mid-WAIT of a DIV -> div_ctrl falls immediately, hi=lo=0, busy=0, and no done pulse.
